// File: rtl/alu_issue_stage.sv
// Issue stage between the ALU decoder and the ALU: holds one decoded op,
// waits out its class latency, then presents it with a valid/ready handshake.
module alu_issue_stage #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3,
  parameter int FP_LAT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        alu_opcode_in,
  input  logic [2:0]        shifter_mode_in,
  input  logic              add_sub_in,
  input  logic              fp_add_sub_in,
  input  logic              cmp_signed_in,
  input  logic              mul_signed_in,
  input  logic              negate_in,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [4:0]        dest_in,
  input  logic              flush,
  output logic [7:0]        alu_opcode_q,
  output logic [2:0]        shifter_mode_q,
  output logic              add_sub_q,
  output logic              fp_add_sub_q,
  output logic              cmp_signed_q,
  output logic              mul_signed_q,
  output logic              negate_q,
  output logic [DATA_W-1:0] op_a_q,
  output logic [DATA_W-1:0] op_b_q,
  output logic [4:0]        dest_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  // state | meaning
  // IDLE  | nothing held, ready to accept
  // WAIT  | op held, counting down its latency
  // VALID | op held and presented to the ALU
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  localparam logic [7:0] ALU_NOP   = 8'h00;
  localparam logic [7:0] ALU_MULH  = 8'h10;
  localparam logic [7:0] ALU_UMULH = 8'h11;
  localparam logic [7:0] ALU_MULL  = 8'h12;
  localparam logic [7:0] ALU_UMULL = 8'h13;
  localparam logic [7:0] ALU_FADD  = 8'h20;
  localparam logic [7:0] ALU_FSUB  = 8'h21;
  localparam logic [7:0] ALU_FMUL  = 8'h22;
  localparam logic [7:0] ALU_FCMP  = 8'h23;
  localparam logic [7:0] ALU_ITOF  = 8'h24;
  localparam logic [7:0] ALU_FTOI  = 8'h25;
  localparam logic [2:0] SH_LSL    = 3'd0;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] FP_CNT  = 4'(FP_LAT - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       accept;
  logic       is_mul;
  logic       is_fp;

  always_comb begin
    is_mul = 1'b0;
    is_fp  = 1'b0;
    case (alu_opcode_in)
      ALU_MULH, ALU_UMULH, ALU_MULL, ALU_UMULL:                 is_mul = 1'b1;
      ALU_FADD, ALU_FSUB, ALU_FMUL, ALU_FCMP, ALU_ITOF, ALU_FTOI: is_fp  = 1'b1;
      default: ;
    endcase
  end

  assign in_ready  = !flush && ((state == S_IDLE) || ((state == S_VALID) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_VALID);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      alu_opcode_q   <= ALU_NOP;
      shifter_mode_q <= SH_LSL;
      add_sub_q      <= 1'b0;
      fp_add_sub_q   <= 1'b0;
      cmp_signed_q   <= 1'b0;
      mul_signed_q   <= 1'b0;
      negate_q       <= 1'b0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      dest_q         <= 5'd0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else if (accept) begin
      // A NOP is swallowed here so it never reaches the ALU.
      if (alu_opcode_in == ALU_NOP) begin
        state <= S_IDLE;
        cnt   <= 4'd0;
      end else begin
        alu_opcode_q   <= alu_opcode_in;
        shifter_mode_q <= shifter_mode_in;
        add_sub_q      <= add_sub_in;
        fp_add_sub_q   <= fp_add_sub_in;
        cmp_signed_q   <= cmp_signed_in;
        mul_signed_q   <= mul_signed_in;
        negate_q       <= negate_in;
        op_a_q         <= operand_a;
        op_b_q         <= operand_b;
        dest_q         <= dest_in;
        if (is_mul) begin
          state <= S_WAIT;
          cnt   <= MUL_CNT;
        end else if (is_fp) begin
          state <= S_WAIT;
          cnt   <= FP_CNT;
        end else begin
          state <= S_VALID;
          cnt   <= 4'd0;
        end
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state <= S_VALID;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_VALID: if (out_ready) state <= S_IDLE;
        S_IDLE:  ;
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: vector table, directed corner sequences and a
// randomized run against a cycle-stamped reference model.
module tb_alu_issue_stage;

  localparam int DW = 32;
  localparam int ML = 3;
  localparam int FL = 4;

  localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h01, OP_SUB = 8'h02,
                         OP_AND = 8'h03, OP_OR = 8'h04, OP_XOR = 8'h05,
                         OP_SLL = 8'h06, OP_MULH = 8'h10, OP_UMULH = 8'h11,
                         OP_MULL = 8'h12, OP_UMULL = 8'h13, OP_FADD = 8'h20,
                         OP_FSUB = 8'h21, OP_FMUL = 8'h22, OP_FCMP = 8'h23,
                         OP_ITOF = 8'h24, OP_FTOI = 8'h25;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [7:0]    alu_opcode_in, alu_opcode_q;
  logic [2:0]    shifter_mode_in, shifter_mode_q;
  logic          add_sub_in, fp_add_sub_in, cmp_signed_in, mul_signed_in, negate_in;
  logic          add_sub_q, fp_add_sub_q, cmp_signed_q, mul_signed_q, negate_q;
  logic [DW-1:0] operand_a, operand_b, op_a_q, op_b_q;
  logic [4:0]    dest_in, dest_q;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_stage #(.DATA_W(DW), .MUL_LAT(ML), .FP_LAT(FL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_opcode_in(alu_opcode_in), .shifter_mode_in(shifter_mode_in),
    .add_sub_in(add_sub_in), .fp_add_sub_in(fp_add_sub_in),
    .cmp_signed_in(cmp_signed_in), .mul_signed_in(mul_signed_in),
    .negate_in(negate_in), .operand_a(operand_a), .operand_b(operand_b),
    .dest_in(dest_in), .flush(flush), .alu_opcode_q(alu_opcode_q),
    .shifter_mode_q(shifter_mode_q), .add_sub_q(add_sub_q),
    .fp_add_sub_q(fp_add_sub_q), .cmp_signed_q(cmp_signed_q),
    .mul_signed_q(mul_signed_q), .negate_q(negate_q), .op_a_q(op_a_q),
    .op_b_q(op_b_q), .dest_q(dest_q), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    dest;
    logic [2:0]    sh;
    logic [4:0]    ctl;
    int            lat;
  } vec_t;

  vec_t vecs[10];

  function automatic int ref_lat(input logic [7:0] op);
    if (op inside {OP_MULH, OP_UMULH, OP_MULL, OP_UMULL}) return ML;
    if (op inside {OP_FADD, OP_FSUB, OP_FMUL, OP_FCMP, OP_ITOF, OP_FTOI}) return FL;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [4:0] d, input logic [2:0] sh,
                       input logic [4:0] ctl, input logic ordy, input logic fl);
    in_valid = v; alu_opcode_in = op; operand_a = a; operand_b = b; dest_in = d;
    shifter_mode_in = sh;
    {add_sub_in, fp_add_sub_in, cmp_signed_in, mul_signed_in, negate_in} = ctl;
    out_ready = ordy; flush = fl;
  endtask

  task automatic idle_in(input logic ordy);
    drive(1'b0, OP_NOP, '0, '0, 5'd0, 3'd0, 5'd0, ordy, 1'b0);
  endtask

  function automatic logic [4:0] ctl_q();
    return {add_sub_q, fp_add_sub_q, cmp_signed_q, mul_signed_q, negate_q};
  endfunction

  task automatic chk_fields(input string tag, input logic [7:0] op, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [4:0] d,
                            input logic [2:0] sh, input logic [4:0] ctl);
    chk({tag, ".opcode"}, alu_opcode_q, op);
    chk({tag, ".op_a"}, op_a_q, a);
    chk({tag, ".op_b"}, op_b_q, b);
    chk({tag, ".dest"}, dest_q, d);
    chk({tag, ".shmode"}, shifter_mode_q, sh);
    chk({tag, ".ctl"}, ctl_q(), ctl);
  endtask

  // reference model state: op held, and the cycle number at which it shows valid
  logic          m_active;
  int            m_valid_at;
  logic [7:0]    m_op;
  logic [DW-1:0] m_a, m_b;
  logic [4:0]    m_d, m_ctl;
  logic [2:0]    m_sh;

  initial begin
    int waited;
    logic [7:0] ops[9];
    vecs[0] = '{OP_ADD,   32'd5,        32'd7,        5'd3,  3'd0, 5'b10000, 1};
    vecs[1] = '{OP_SUB,   32'hFFFF0000, 32'h1,        5'd31, 3'd1, 5'b00001, 1};
    vecs[2] = '{OP_XOR,   32'hA5A5A5A5, 32'h5A5A5A5A, 5'd0,  3'd7, 5'b00100, 1};
    vecs[3] = '{OP_SLL,   32'h1,        32'd31,       5'd17, 3'd2, 5'b00000, 1};
    vecs[4] = '{OP_MULL,  32'd1234,     32'd5678,     5'd8,  3'd0, 5'b00010, ML};
    vecs[5] = '{OP_UMULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  3'd0, 5'b00000, ML};
    vecs[6] = '{OP_FADD,  32'h3F800000, 32'h40000000, 5'd10, 3'd0, 5'b01000, FL};
    vecs[7] = '{OP_FTOI,  32'h42280000, 32'h0,        5'd11, 3'd0, 5'b00000, FL};
    vecs[8] = '{OP_FCMP,  32'h1,        32'h2,        5'd12, 3'd0, 5'b00100, FL};
    vecs[9] = '{OP_MULH,  32'h80000000, 32'h2,        5'd13, 3'd0, 5'b00010, ML};
    ops = '{OP_NOP, OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_MULH, OP_UMULL, OP_FADD, OP_FTOI};

    rst_n = 1'b0;
    idle_in(1'b1);
    #12;
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk_fields("rst", OP_NOP, '0, '0, 5'd0, 3'd0, 5'd0);
    rst_n = 1'b1;
    step();
    chk("rst.in_ready", in_ready, 1'b1);

    // table: latency and latched fields for each class
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].sh,
            vecs[i].ctl, 1'b1, 1'b0);
      step();
      idle_in(1'b1);
      waited = 1;
      while (!out_valid && waited < 20) begin
        chk("tbl.busy_wait", busy, 1'b1);
        chk("tbl.in_ready_wait", in_ready, 1'b0);
        step();
        waited++;
      end
      chk("tbl.latency", waited, vecs[i].lat);
      chk_fields("tbl", vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].sh, vecs[i].ctl);
      step();
      chk("tbl.drain", out_valid, 1'b0);
    end

    // ADD 5+7 -> dest 3, one-cycle latency, back to IDLE on out_ready
    drive(1'b1, OP_ADD, 32'd5, 32'd7, 5'd3, 3'd0, 5'd0, 1'b1, 1'b0);
    #1 chk("add.in_ready", in_ready, 1'b1);
    step(); idle_in(1'b1); #1;
    chk("add.valid_c1", out_valid, 1'b1);
    chk_fields("add", OP_ADD, 32'd5, 32'd7, 5'd3, 3'd0, 5'd0);
    step();
    chk("add.valid_c2", out_valid, 1'b0);
    chk("add.busy_c2", busy, 1'b0);

    // MULL: stalled in cycles 1-2, valid in cycle 3
    drive(1'b1, OP_MULL, 32'd3, 32'd4, 5'd1, 3'd0, 5'd0, 1'b1, 1'b0);
    step(); drive(1'b1, OP_ADD, 32'd9, 32'd9, 5'd9, 3'd0, 5'd0, 1'b1, 1'b0); #1;
    for (int c = 1; c <= 2; c++) begin
      chk("mull.in_ready", in_ready, 1'b0);
      chk("mull.busy", busy, 1'b1);
      chk("mull.valid_early", out_valid, 1'b0);
      step(); #1;
    end
    chk("mull.valid_c3", out_valid, 1'b1);
    chk("mull.opcode", alu_opcode_q, OP_MULL);
    idle_in(1'b1);
    step();

    // SUB held 5 cycles, then OR accepted back-to-back
    drive(1'b1, OP_SUB, 32'd100, 32'd40, 5'd6, 3'd0, 5'b10000, 1'b0, 1'b0);
    step();
    drive(1'b1, OP_OR, 32'hF0, 32'h0F, 5'd7, 3'd3, 5'b00001, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold.valid", out_valid, 1'b1);
      chk("hold.in_ready", in_ready, 1'b0);
      chk_fields("hold", OP_SUB, 32'd100, 32'd40, 5'd6, 3'd0, 5'b10000);
      step();
    end
    out_ready = 1'b1;
    #1 chk("b2b.in_ready", in_ready, 1'b1);
    step(); idle_in(1'b0); #1;
    chk("b2b.valid", out_valid, 1'b1);
    chk_fields("b2b", OP_OR, 32'hF0, 32'h0F, 5'd7, 3'd3, 5'b00001);
    out_ready = 1'b1;
    step();

    // NOP consumed silently
    drive(1'b1, OP_NOP, 32'd1, 32'd2, 5'd4, 3'd0, 5'd0, 1'b1, 1'b0);
    step(); idle_in(1'b1); #1;
    chk("nop.valid", out_valid, 1'b0);
    chk("nop.busy", busy, 1'b0);
    step();
    chk("nop.valid2", out_valid, 1'b0);

    // flush during FMUL wait; op offered in the flush cycle is dropped
    drive(1'b1, OP_FMUL, 32'd1, 32'd2, 5'd5, 3'd0, 5'd0, 1'b1, 1'b0);
    step();
    drive(1'b1, OP_ADD, 32'd8, 32'd8, 5'd8, 3'd0, 5'd0, 1'b1, 1'b1);
    #1 chk("flush.in_ready", in_ready, 1'b0);
    step(); idle_in(1'b1); #1;
    chk("flush.valid_c2", out_valid, 1'b0);
    chk("flush.busy_c2", busy, 1'b0);
    chk("flush.in_ready_c2", in_ready, 1'b1);
    for (int c = 0; c < FL + 1; c++) begin
      step();
      chk("flush.no_late_valid", out_valid, 1'b0);
    end

    // async reset during VALID
    drive(1'b1, OP_XOR, 32'h55, 32'hAA, 5'd21, 3'd5, 5'b11111, 1'b0, 1'b0);
    step(); idle_in(1'b0);
    #1 chk("arst.pre_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.valid", out_valid, 1'b0);
    chk("arst.busy", busy, 1'b0);
    chk_fields("arst", OP_NOP, '0, '0, 5'd0, 3'd0, 5'd0);
    #2 rst_n = 1'b1;
    step();
    chk("arst.in_ready_after", in_ready, 1'b1);
    chk("arst.busy_after", busy, 1'b0);

    // randomized run against the cycle-stamped model
    m_active = 1'b0; m_valid_at = 0;
    m_op = OP_NOP; m_a = '0; m_b = '0; m_d = '0; m_ctl = '0; m_sh = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic exp_valid, exp_ready, fl, ordy, v;
      logic [7:0] op;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      op   = ops[$urandom_range(0, 8)];
      drive(v, op, $urandom, $urandom, 5'($urandom), 3'($urandom), 5'($urandom), ordy, fl);
      #1;
      exp_valid = m_active && (cyc >= m_valid_at);
      exp_ready = !fl && (!m_active || (exp_valid && ordy));
      chk("rnd.out_valid", out_valid, exp_valid);
      chk("rnd.busy", busy, m_active);
      chk("rnd.in_ready", in_ready, exp_ready);
      if (exp_valid) chk_fields("rnd", m_op, m_a, m_b, m_d, m_sh, m_ctl);
      if (fl) m_active = 1'b0;
      else if (v && exp_ready) begin
        if (op == OP_NOP) m_active = 1'b0;
        else begin
          m_active = 1'b1; m_valid_at = cyc + ref_lat(op);
          m_op = op; m_a = operand_a; m_b = operand_b; m_d = dest_in;
          m_sh = shifter_mode_in;
          m_ctl = {add_sub_in, fp_add_sub_in, cmp_signed_in, mul_signed_in, negate_in};
        end
      end else if (exp_valid && ordy) m_active = 1'b0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
